pic_bus_sequencer: RTL

PIC_BUS_SEQUENCER -- requirements
Module: pic_bus_sequencer

---
 rtl/pic_pkg.sv | 12 +
 rtl/pic_strobe_edge.sv | 12 +
 rtl/pic_bus_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// pic_pkg: shared FSM states, command bit positions and read-select encoding
package pic_pkg;
    typedef enum logic [1:0] {READY, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4} pic_state_t;
    typedef enum logic {SEL_IRR = 1'b0, SEL_ISR = 1'b1} read_sel_t;
    localparam int IC4     = 0;
    localparam int SNGL    = 1;
    localparam int RIS     = 0;
    localparam int RR      = 1;
    localparam int P       = 2;
    localparam int OCW_SEL = 3;
    localparam int ICW1_ID = 4;
endpackage

// File: rtl/pic_strobe_edge.sv
// pic_strobe_edge: registers a level and flags its trailing (1->0) edge
module pic_strobe_edge (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic level_q,
    output logic fall
);
    // previous-cycle copy of the level
    always_ff @(posedge clk) level_q <= reset ? 1'b0 : level;
    assign fall = level_q & ~level;
endmodule

// File: rtl/pic_bus_sequencer.sv
// pic_bus_sequencer: CPU bus front end decoding ICW/OCW writes and register reads
module pic_bus_sequencer
    import pic_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              a0,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    input  logic [DATA_W-1:0] irr,
    input  logic [DATA_W-1:0] isr,
    input  logic [DATA_W-1:0] imr,
    input  logic [DATA_W-1:0] poll_vector,
    output logic [DATA_W-1:0] internal_data_bus,
    output logic              icw1_stb,
    output logic              icw2_stb,
    output logic              icw3_stb,
    output logic              icw4_stb,
    output logic              ocw1_stb,
    output logic              ocw2_stb,
    output logic              ocw3_stb,
    output logic              init_busy,
    output logic              poll_ack
);
    logic       wr_flag, rd_flag, wr_q, rd_q, wr_fall, rd_fall;
    logic       a0_q, a0_rd, sngl, ic4, poll_pending, poll_done;
    logic       is_icw1, is_ocw2, is_ocw3, in_ready;
    logic       icw1_d, icw2_d, icw3_d, icw4_d, ocw1_d, ocw2_d, ocw3_d;
    logic [6:0] stb_q;
    read_sel_t  read_sel;
    pic_state_t state, state_n;

    assign wr_flag = ~cs_n & ~wr_n;
    assign rd_flag = ~cs_n & ~rd_n;

    pic_strobe_edge u_wr_edge (.clk(clk), .reset(reset), .level(wr_flag), .level_q(wr_q), .fall(wr_fall));
    pic_strobe_edge u_rd_edge (.clk(clk), .reset(reset), .level(rd_flag), .level_q(rd_q), .fall(rd_fall));

    assign is_icw1  = ~a0_q & internal_data_bus[ICW1_ID];
    assign is_ocw2  = ~a0_q & ~internal_data_bus[ICW1_ID] & ~internal_data_bus[OCW_SEL];
    assign is_ocw3  = ~a0_q & ~internal_data_bus[ICW1_ID] & internal_data_bus[OCW_SEL];
    assign in_ready = state == READY;
    // a read that overlapped a write must not consume the poll
    assign poll_done = rd_fall & rd_q & ~wr_q & ~wr_flag & ~a0_rd & poll_pending;

    // latch write data and address every cycle the write strobe is active
    always_ff @(posedge clk) begin
        if (reset) begin
            internal_data_bus <= '0;
            a0_q              <= 1'b0;
        end else if (wr_flag) begin
            internal_data_bus <= data_in;
            a0_q              <= a0;
        end
    end

    // remember which register the current read addresses
    always_ff @(posedge clk) a0_rd <= reset ? 1'b0 : (rd_flag ? a0 : a0_rd);

    // FSM state register
    always_ff @(posedge clk) state <= reset ? READY : state_n;

    // next state, advanced only by a committed write
    always_comb begin
        state_n = state;
        if (wr_fall) begin
            if (is_icw1) state_n = WAIT_ICW2;
            else if (a0_q) begin
                case (state)
                    WAIT_ICW2: state_n = !sngl ? WAIT_ICW3 : (ic4 ? WAIT_ICW4 : READY);
                    WAIT_ICW3: state_n = ic4 ? WAIT_ICW4 : READY;
                    WAIT_ICW4: state_n = READY;
                    default:   state_n = state;
                endcase
            end
        end
    end

    // strobe decode; OCW2/OCW3 patterns are dropped during initialisation
    always_comb begin
        icw1_d = wr_fall & is_icw1;
        icw2_d = wr_fall & a0_q & (state == WAIT_ICW2);
        icw3_d = wr_fall & a0_q & (state == WAIT_ICW3);
        icw4_d = wr_fall & a0_q & (state == WAIT_ICW4);
        ocw1_d = wr_fall & a0_q & in_ready;
        ocw2_d = wr_fall & is_ocw2 & in_ready;
        ocw3_d = wr_fall & is_ocw3 & in_ready;
    end

    // one-cycle registered strobes
    always_ff @(posedge clk) stb_q <= reset ? 7'd0 : {icw1_d, icw2_d, icw3_d, icw4_d, ocw1_d, ocw2_d, ocw3_d};

    assign {icw1_stb, icw2_stb, icw3_stb, icw4_stb, ocw1_stb, ocw2_stb, ocw3_stb} = stb_q;
    assign init_busy = ~in_ready;

    // ICW1 mode bits
    always_ff @(posedge clk) begin
        if (reset) begin
            sngl <= 1'b0;
            ic4  <= 1'b0;
        end else if (icw1_d) begin
            sngl <= internal_data_bus[SNGL];
            ic4  <= internal_data_bus[IC4];
        end
    end

    // read selection and poll handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            read_sel     <= SEL_IRR;
            poll_pending <= 1'b0;
            poll_ack     <= 1'b0;
        end else begin
            poll_ack <= poll_done;
            if (icw1_d) begin
                read_sel     <= SEL_IRR;
                poll_pending <= 1'b0;
            end else if (ocw3_d) begin
                if (internal_data_bus[RR]) read_sel <= read_sel_t'(internal_data_bus[RIS]);
                if (internal_data_bus[P]) poll_pending <= 1'b1;
            end else if (poll_done) poll_pending <= 1'b0;
        end
    end

    assign data_oe  = rd_flag & ~wr_flag;
    assign data_out = a0 ? imr : poll_pending ? poll_vector : (read_sel == SEL_ISR) ? isr : irr;
endmodule
